// File: rtl/timer_irq_pkg.sv
// Shared constants for the countdown timer: register map, CTRL bit fields,
// mode encodings and FSM state encoding.
package timer_irq_pkg;

    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_PEND     = 4;

    localparam logic [1:0] TIMER_MODE_ONESHOT = 2'd0;
    localparam logic [1:0] TIMER_MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Encodings 2 and 3 fall back to one-shot behaviour.
    function automatic logic mode_is_reload(input logic [1:0] mode);
        return mode == TIMER_MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_irq_if.sv
// Word-indexed register port between the system bridge (master) and the timer.
interface timer_irq_if;
    logic [1:0]  addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_result;

    modport master (output addr, output write_enable, output write_data, input read_result);
    modport slave  (input addr, input write_enable, input write_data, output read_result);
endinterface

// File: rtl/timer_irq.sv
// Memory-mapped countdown timer driving one hwirq bit. One-shot mode holds the
// interrupt until software clears it; auto-reload mode emits one-cycle pulses.
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    timer_irq_if.slave  bus,
    output logic        irq,
    output logic        busy
);

    timer_state_e     state_q, state_d;
    logic             en_q, im_q, pend_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] preset_q, count_q;
    logic [31:0]      rd;

    logic ctrl_wr, preset_wr, stop_wr, cnt_done, reload;

    assign ctrl_wr   = bus.write_enable && (bus.addr == TIMER_CTRL);
    assign preset_wr = bus.write_enable && (bus.addr == TIMER_PRESET);
    assign stop_wr   = ctrl_wr && !bus.write_data[CTRL_EN];
    // A count of 0 or 1 ends the period, so PRESET=0 times like PRESET=1.
    assign cnt_done  = !(count_q > WIDTH'(1));
    assign reload    = mode_is_reload(mode_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: state_d = ST_CNT;
            ST_CNT:  if (cnt_done) state_d = ST_INT;
            ST_INT:  state_d = reload ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A CTRL write overrides the sequencing; EN=1 during LOAD/CNT keeps running.
        if (ctrl_wr) begin
            if (!bus.write_data[CTRL_EN])
                state_d = ST_IDLE;
            else if (state_q == ST_IDLE || state_q == ST_INT)
                state_d = ST_LOAD;
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        irq  = im_q & pend_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            mode_q   <= TIMER_MODE_ONESHOT;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
        end else begin
            if (ctrl_wr) begin
                en_q   <= bus.write_data[CTRL_EN];
                mode_q <= bus.write_data[CTRL_MODE_MSB:CTRL_MODE_LSB];
                im_q   <= bus.write_data[CTRL_IM];
            end else if (state_q == ST_INT && !reload) begin
                en_q <= 1'b0;
            end

            if (preset_wr)
                preset_q <= bus.write_data[WIDTH-1:0];

            if (!stop_wr) begin
                unique case (state_q)
                    ST_LOAD: count_q <= preset_q;
                    ST_CNT:  count_q <= cnt_done ? '0 : count_q - WIDTH'(1);
                    default: count_q <= count_q;
                endcase
            end

            // Any register write acknowledges the interrupt, even on the terminal edge.
            if (ctrl_wr || preset_wr)
                pend_q <= 1'b0;
            else if (state_q == ST_CNT && cnt_done)
                pend_q <= 1'b1;
            else if (state_q == ST_INT && reload)
                pend_q <= 1'b0;
        end
    end

    always_comb begin
        rd = '0;
        unique case (bus.addr)
            TIMER_CTRL: begin
                rd[CTRL_EN]                     = en_q;
                rd[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
                rd[CTRL_IM]                     = im_q;
                rd[CTRL_PEND]                   = pend_q;
            end
            TIMER_PRESET: rd[WIDTH-1:0] = preset_q;
            TIMER_COUNT:  rd[WIDTH-1:0] = count_q;
            default:      rd = '0;
        endcase
    end

    assign bus.read_result = rd;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: vector tables plus hand sequences for
// auto-reload pulsing, masking and asynchronous reset.
module tb_timer_irq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq, busy;

    timer_irq_if bus ();

    timer_irq #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .irq  (irq),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
        logic        busy;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [1:0] a, input logic we, input logic [31:0] wd,
                                input logic [31:0] rd, input logic ei, input logic eb);
        vec_t v;
        v.addr = a; v.we = we; v.wd = wd; v.rd = rd; v.irq = ei; v.busy = eb;
        return v;
    endfunction

    // Check outputs for the state reached so far, then present the inputs on the next edge.
    task automatic step(input logic [1:0] a, input logic we, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eirq, input logic ebusy, input string nm);
        @(negedge clk);
        bus.addr = a; bus.write_enable = we; bus.write_data = wd;
        #1;
        checks++;
        if (bus.read_result !== erd || irq !== eirq || busy !== ebusy) begin
            errors++;
            $display("FAIL %s: got rd=%h irq=%b busy=%b, expected rd=%h irq=%b busy=%b",
                     nm, bus.read_result, irq, busy, erd, eirq, ebusy);
        end
        @(posedge clk);
        #1 bus.write_enable = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic        seen;
        int          p;

        // Reset readback and one-shot PRESET=5 with IM.
        tbl_a.push_back(mk(2'd0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0));
        tbl_a.push_back(mk(2'd1, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0));
        tbl_a.push_back(mk(2'd3, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0));
        tbl_a.push_back(mk(2'd1, 1'b1, 32'h5, 32'h00, 1'b0, 1'b0));
        tbl_a.push_back(mk(2'd0, 1'b1, 32'h9, 32'h00, 1'b0, 1'b0));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h00, 1'b0, 1'b1));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h05, 1'b0, 1'b1));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h04, 1'b0, 1'b1));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h03, 1'b0, 1'b1));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h02, 1'b0, 1'b1));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h01, 1'b0, 1'b1));
        tbl_a.push_back(mk(2'd2, 1'b0, 32'h0, 32'h00, 1'b1, 1'b1));
        tbl_a.push_back(mk(2'd0, 1'b0, 32'h0, 32'h18, 1'b1, 1'b0));
        tbl_a.push_back(mk(2'd0, 1'b0, 32'h0, 32'h18, 1'b1, 1'b0));
        tbl_a.push_back(mk(2'd0, 1'b1, 32'h0, 32'h18, 1'b1, 1'b0));
        tbl_a.push_back(mk(2'd0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0));

        // One-shot PRESET=2 with a CTRL=0x9 rewrite landing on the INT edge.
        tbl_b.push_back(mk(2'd1, 1'b1, 32'h2, 32'h04, 1'b0, 1'b0));
        tbl_b.push_back(mk(2'd0, 1'b1, 32'h9, 32'h00, 1'b0, 1'b0));
        tbl_b.push_back(mk(2'd2, 1'b0, 32'h0, 32'h02, 1'b0, 1'b1));
        tbl_b.push_back(mk(2'd2, 1'b0, 32'h0, 32'h02, 1'b0, 1'b1));
        tbl_b.push_back(mk(2'd2, 1'b0, 32'h0, 32'h01, 1'b0, 1'b1));
        tbl_b.push_back(mk(2'd0, 1'b1, 32'h9, 32'h19, 1'b1, 1'b1));
        tbl_b.push_back(mk(2'd0, 1'b0, 32'h0, 32'h09, 1'b0, 1'b1));
        tbl_b.push_back(mk(2'd2, 1'b0, 32'h0, 32'h02, 1'b0, 1'b1));
        tbl_b.push_back(mk(2'd2, 1'b0, 32'h0, 32'h01, 1'b0, 1'b1));
        tbl_b.push_back(mk(2'd2, 1'b0, 32'h0, 32'h00, 1'b1, 1'b1));
        tbl_b.push_back(mk(2'd0, 1'b1, 32'h0, 32'h18, 1'b1, 1'b0));
        tbl_b.push_back(mk(2'd0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0));

        bus.addr = 2'd0; bus.write_enable = 1'b0; bus.write_data = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl_a[i])
            step(tbl_a[i].addr, tbl_a[i].we, tbl_a[i].wd, tbl_a[i].rd, tbl_a[i].irq,
                 tbl_a[i].busy, $sformatf("oneshot[%0d]", i));

        // Auto-reload PRESET=3: COUNT 3,2,1,0 then a LOAD cycle, irq on the 0 cycle.
        step(2'd1, 1'b1, 32'h3, 32'h5, 1'b0, 1'b0, "reload_preset");
        step(2'd0, 1'b1, 32'hB, 32'h0, 1'b0, 1'b0, "reload_ctrl");
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) begin
                exp_rd = 32'h0; exp_irq = 1'b0;
            end else begin
                p = (k - 1) % 5;
                exp_rd  = (p < 4) ? 32'(3 - p) : 32'h0;
                exp_irq = (p == 3);
            end
            step(2'd2, 1'b0, 32'h0, exp_rd, exp_irq, 1'b1, $sformatf("reload[%0d]", k));
        end
        step(2'd0, 1'b1, 32'h0, 32'hB, 1'b0, 1'b1, "reload_stop");
        for (int k = 0; k < 3; k++)
            step(2'd2, 1'b0, 32'h0, 32'h2, 1'b0, 1'b0, $sformatf("reload_frozen[%0d]", k));

        // Masked auto-reload PRESET=4: PEND visible in CTRL, irq never rises.
        step(2'd1, 1'b1, 32'h4, 32'h3, 1'b0, 1'b0, "masked_preset");
        step(2'd0, 1'b1, 32'h3, 32'h0, 1'b0, 1'b0, "masked_ctrl");
        for (int k = 0; k <= 20; k++) begin
            exp_rd = 32'h3;
            if (k > 0 && ((k - 1) % 6) == 4) exp_rd = 32'h13;
            step(2'd0, 1'b0, 32'h0, exp_rd, 1'b0, 1'b1, $sformatf("masked[%0d]", k));
        end
        step(2'd0, 1'b1, 32'h0, 32'h3, 1'b0, 1'b1, "masked_stop");

        foreach (tbl_b[i])
            step(tbl_b[i].addr, tbl_b[i].we, tbl_b[i].wd, tbl_b[i].rd, tbl_b[i].irq,
                 tbl_b[i].busy, $sformatf("restart[%0d]", i));

        // Asynchronous reset while irq is asserted.
        step(2'd1, 1'b1, 32'h3, 32'h2, 1'b0, 1'b0, "arst_preset");
        step(2'd0, 1'b1, 32'hB, 32'h0, 1'b0, 1'b0, "arst_ctrl");
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (irq === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("arst_irq_seen", {31'h0, seen}, 32'h1);
        rst = 1'b0;
        bus.addr = 2'd0;
        #1;
        chk("arst_irq", {31'h0, irq}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_ctrl_rd", bus.read_result, 32'h0);
        bus.addr = 2'd1;
        #1 chk("arst_preset_rd", bus.read_result, 32'h0);
        bus.addr = 2'd2;
        #1 chk("arst_count_rd", bus.read_result, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++)
            step(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, $sformatf("post_rst[%0d]", k));

        // COUNT is read-only: a write mid-count leaves the decrement undisturbed.
        step(2'd1, 1'b1, 32'h7, 32'h0, 1'b0, 1'b0, "ro_preset");
        step(2'd0, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0, "ro_ctrl");
        step(2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "ro_load");
        step(2'd2, 1'b0, 32'h0, 32'h7, 1'b0, 1'b1, "ro_cnt7");
        step(2'd2, 1'b1, 32'h55, 32'h6, 1'b0, 1'b1, "ro_write");
        step(2'd2, 1'b0, 32'h0, 32'h5, 1'b0, 1'b1, "ro_cnt5");
        step(2'd2, 1'b0, 32'h0, 32'h4, 1'b0, 1'b1, "ro_cnt4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
